regfile_write_arbiter: RTL and testbench

- Shares the register file's single write port between two writeback requesters: A (ALU result) and B (load/memory result).
- Each requester gets a one-entry holding buffer with a valid/ready handshake.
- A round-robin arbiter issues at most one registered write per cycle onto the register file's write_reg/write_data/reg_write/En inputs.
- Keeps a saturating count of issued writes for debug and performance.

---
 rtl/regfile_write_arbiter.sv | 131 +++++++++++++
 tb/tb_regfile_write_arbiter.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter
//   Shares the register file's single write port between two writeback
//   requesters: A (ALU result) and B (load result). Each requester has a
//   one-entry holding buffer with a valid/ready handshake. A round-robin
//   arbiter issues at most one registered write per cycle.
//
// Ports
//   Clk, Rst                         clock, async active-high reset
//   a_valid/a_reg/a_data/a_ready     requester A handshake
//   b_valid/b_reg/b_data/b_ready     requester B handshake
//   rf_write_reg/rf_write_data       register file write address/data
//   rf_reg_write/rf_En               register file write strobes
//   busy                             either holding buffer full
//   wr_count                         saturating count of issued writes
//
// Build option
//   REGFILE_ZERO_REG_EN : register 0 is hardwired zero; buffered writes to
//   it are consumed in their grant slot without strobing the register file.
module regfile_write_arbiter #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 16
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              a_valid,
  input  logic [ADDR_W-1:0] a_reg,
  input  logic [DATA_W-1:0] a_data,
  output logic              a_ready,
  input  logic              b_valid,
  input  logic [ADDR_W-1:0] b_reg,
  input  logic [DATA_W-1:0] b_data,
  output logic              b_ready,
  output logic [ADDR_W-1:0] rf_write_reg,
  output logic [DATA_W-1:0] rf_write_data,
  output logic              rf_reg_write,
  output logic              rf_En,
  output logic              busy,
  output logic [CNT_W-1:0]  wr_count
);

  logic              r_full_a, r_full_b;
  logic [ADDR_W-1:0] r_reg_a, r_reg_b;
  logic [DATA_W-1:0] r_data_a, r_data_b;
  logic              r_last_b;   // 1: last grant went to B
  logic [CNT_W-1:0]  r_cnt;

  logic w_issue_a, w_issue_b;
  logic w_zero_a, w_zero_b;
  logic w_wr_a, w_wr_b, w_write;
  logic w_acc_a, w_acc_b;

  // Grant depends only on buffer state, so ready never depends on valid.
  assign w_issue_a = r_full_a && (!r_full_b || r_last_b);
  assign w_issue_b = r_full_b && (!r_full_a || !r_last_b);

`ifdef REGFILE_ZERO_REG_EN
  assign w_zero_a = (r_reg_a == '0);
  assign w_zero_b = (r_reg_b == '0);
`else
  assign w_zero_a = 1'b0;
  assign w_zero_b = 1'b0;
`endif

  // A zero-register grant still frees its buffer but drives no write.
  assign w_wr_a  = w_issue_a && !w_zero_a;
  assign w_wr_b  = w_issue_b && !w_zero_b;
  assign w_write = w_wr_a || w_wr_b;

  assign a_ready = !r_full_a || w_issue_a;
  assign b_ready = !r_full_b || w_issue_b;
  assign w_acc_a = a_valid && a_ready;
  assign w_acc_b = b_valid && b_ready;

  assign busy     = r_full_a || r_full_b;
  assign wr_count = r_cnt;

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_full_a <= 1'b0;
      r_full_b <= 1'b0;
      r_reg_a  <= '0;
      r_reg_b  <= '0;
      r_data_a <= '0;
      r_data_b <= '0;
      r_last_b <= 1'b1;
    end else begin
      // Refill takes priority over free when both happen on one edge.
      if (w_acc_a) begin
        r_full_a <= 1'b1;
        r_reg_a  <= a_reg;
        r_data_a <= a_data;
      end else if (w_issue_a) begin
        r_full_a <= 1'b0;
      end
      if (w_acc_b) begin
        r_full_b <= 1'b1;
        r_reg_b  <= b_reg;
        r_data_b <= b_data;
      end else if (w_issue_b) begin
        r_full_b <= 1'b0;
      end
      if (w_issue_a)      r_last_b <= 1'b0;
      else if (w_issue_b) r_last_b <= 1'b1;
    end
  end

  // Registered write port: address/data hold their last value when idle.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      rf_write_reg  <= '0;
      rf_write_data <= '0;
      rf_reg_write  <= 1'b0;
      rf_En         <= 1'b0;
      r_cnt         <= '0;
    end else begin
      rf_reg_write <= w_write;
      rf_En        <= w_write;
      if (w_wr_a) begin
        rf_write_reg  <= r_reg_a;
        rf_write_data <= r_data_a;
      end else if (w_wr_b) begin
        rf_write_reg  <= r_reg_b;
        rf_write_data <= r_data_b;
      end
      if (w_write && (r_cnt != '1))
        r_cnt <= r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter. Counter width is reduced so the
// saturation boundary is reachable in a short run.
module tb_regfile_write_arbiter;
  localparam int DW = 64;
  localparam int AW = 5;
  localparam int CW = 4;

  logic          Clk = 1'b0;
  logic          Rst;
  logic          a_valid, b_valid;
  logic [AW-1:0] a_reg, b_reg;
  logic [DW-1:0] a_data, b_data;
  logic          a_ready, b_ready;
  logic [AW-1:0] rf_write_reg;
  logic [DW-1:0] rf_write_data;
  logic          rf_reg_write, rf_En, busy;
  logic [CW-1:0] wr_count;

  regfile_write_arbiter #(.DATA_W(DW), .ADDR_W(AW), .CNT_W(CW)) dut (
    .Clk(Clk), .Rst(Rst),
    .a_valid(a_valid), .a_reg(a_reg), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_reg(b_reg), .b_data(b_data), .b_ready(b_ready),
    .rf_write_reg(rf_write_reg), .rf_write_data(rf_write_data),
    .rf_reg_write(rf_reg_write), .rf_En(rf_En),
    .busy(busy), .wr_count(wr_count)
  );

  always #5 Clk = ~Clk;

  // Register file model fed by the write port.
  logic [DW-1:0] rf_mem [32];
  always @(posedge Clk) if (rf_reg_write && rf_En) rf_mem[rf_write_reg] <= rf_write_data;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic do_reset();
    @(negedge Clk);
    Rst = 1'b1; a_valid = 1'b0; b_valid = 1'b0;
    @(negedge Clk);
    Rst = 1'b0;
  endtask

  logic          acc_a, acc_b;
  int            ia, ib, nrec, pulses;
  logic [AW-1:0] rec_reg  [8];
  logic [DW-1:0] rec_data [8];
  logic          zero_en;

  initial begin
`ifdef REGFILE_ZERO_REG_EN
    zero_en = 1'b1;
`else
    zero_en = 1'b0;
`endif
    Rst = 1'b1; a_valid = 0; b_valid = 0;
    a_reg = '0; b_reg = '0; a_data = '0; b_data = '0;
    repeat (2) @(negedge Clk);
    chk("rst_reg_write", rf_reg_write, 0);
    chk("rst_en",        rf_En, 0);
    chk("rst_wreg",      rf_write_reg, 0);
    chk("rst_wdata",     rf_write_data, 0);
    chk("rst_busy",      busy, 0);
    chk("rst_count",     wr_count, 0);
    chk("rst_a_ready",   a_ready, 1);
    chk("rst_b_ready",   b_ready, 1);
    Rst = 1'b0;

    // Reset mid-operation discards an accepted, not yet issued write
    @(negedge Clk); a_valid = 1; a_reg = 3; a_data = 'h11;
    @(negedge Clk); a_valid = 0;
    chk("mid_busy_before", busy, 1);
    Rst = 1'b1; #1;
    chk("mid_busy_after", busy, 0);
    chk("mid_a_ready", a_ready, 1);
    @(negedge Clk); Rst = 1'b0;
    pulses = 0;
    repeat (3) begin @(negedge Clk); if (rf_reg_write) pulses++; end
    chk("mid_no_pulse", pulses, 0);
    chk("mid_count", wr_count, 0);
    chk("mid_wreg", rf_write_reg, 0);

    // Single A write, latency T+2
    @(negedge Clk); a_valid = 1; a_reg = 5; a_data = 64'hDEAD_BEEF;
    @(negedge Clk); a_valid = 0;
    chk("single_t1_idle", rf_reg_write, 0);
    @(negedge Clk);
    chk("single_we",    rf_reg_write, 1);
    chk("single_en",    rf_En, 1);
    chk("single_reg",   rf_write_reg, 5);
    chk("single_data",  rf_write_data, 64'hDEAD_BEEF);
    chk("single_count", wr_count, 1);
    @(negedge Clk);
    chk("single_drop",  rf_reg_write, 0);
    chk("single_hold",  rf_write_data, 64'hDEAD_BEEF);

    // Simultaneous A and B: A first after reset
    do_reset();
    @(negedge Clk);
    a_valid = 1; a_reg = 1; a_data = 'hA;
    b_valid = 1; b_reg = 2; b_data = 'hB;
    chk("sim_a_ready", a_ready, 1);
    chk("sim_b_ready", b_ready, 1);
    @(negedge Clk); a_valid = 0; b_valid = 0;
    chk("sim_busy", busy, 1);
    @(negedge Clk);
    chk("sim_first_we",   rf_reg_write, 1);
    chk("sim_first_reg",  rf_write_reg, 1);
    chk("sim_first_data", rf_write_data, 'hA);
    @(negedge Clk);
    chk("sim_second_we",   rf_reg_write, 1);
    chk("sim_second_reg",  rf_write_reg, 2);
    chk("sim_second_data", rf_write_data, 'hB);
    chk("sim_count", wr_count, 2);
    @(negedge Clk);
    chk("sim_idle", busy, 0);

    // Continuous dual traffic: four items per side, issue order alternates
    do_reset();
    ia = 0; ib = 0; nrec = 0; acc_a = 0; acc_b = 0;
    for (int cyc = 0; cyc < 30; cyc++) begin
      @(negedge Clk);
      if (rf_reg_write) begin
        if (nrec < 8) begin rec_reg[nrec] = rf_write_reg; rec_data[nrec] = rf_write_data; end
        nrec++;
      end
      if (acc_a) ia++;
      if (acc_b) ib++;
      a_valid = (ia < 4); a_reg = AW'(10 + ia); a_data = 64'hA0 + 64'(ia);
      b_valid = (ib < 4); b_reg = AW'(20 + ib); b_data = 64'hB0 + 64'(ib);
      acc_a = a_valid && a_ready;
      acc_b = b_valid && b_ready;
    end
    a_valid = 0; b_valid = 0;
    chk("dual_writes", nrec, 8);
    for (int k = 0; k < 8; k++) begin
      if (k < nrec) begin
        chk($sformatf("dual_reg%0d", k), rec_reg[k],
            (k % 2 == 0) ? 64'(10 + k / 2) : 64'(20 + k / 2));
        chk($sformatf("dual_data%0d", k), rec_data[k],
            (k % 2 == 0) ? 64'hA0 + 64'(k / 2) : 64'hB0 + 64'(k / 2));
      end
    end
    chk("dual_count", wr_count, 8);

    // Same destination: A then B, B's data persists
    do_reset();
    @(negedge Clk);
    a_valid = 1; a_reg = 7; a_data = 'h1;
    b_valid = 1; b_reg = 7; b_data = 'h2;
    @(negedge Clk); a_valid = 0; b_valid = 0;
    @(negedge Clk);
    chk("same_first_reg",  rf_write_reg, 7);
    chk("same_first_data", rf_write_data, 'h1);
    @(negedge Clk);
    chk("same_second_reg",  rf_write_reg, 7);
    chk("same_second_data", rf_write_data, 'h2);
    @(negedge Clk);
    chk("same_mem7", rf_mem[7], 'h2);
    chk("same_count", wr_count, 2);

    // Write to register 0
    do_reset();
    @(negedge Clk); a_valid = 1; a_reg = 0; a_data = 'hFF;
    @(negedge Clk); a_valid = 0;
    chk("zero_a_ready", a_ready, 1);
    @(negedge Clk);
    chk("zero_we",    rf_reg_write, zero_en ? 0 : 1);
    chk("zero_count", wr_count, zero_en ? 0 : 1);
    chk("zero_busy",  busy, 0);

    // Counter saturation: 20 back-to-back A writes into a 4-bit counter
    do_reset();
    for (int i = 0; i < 20; i++) begin
      @(negedge Clk); a_valid = 1; a_reg = AW'(1 + i); a_data = 64'(i);
    end
    @(negedge Clk); a_valid = 0;
    repeat (3) @(negedge Clk);
    chk("sat_count", wr_count, 15);
    chk("sat_idle",  busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
